uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller for the UART path. It synchronises the raw `rxd` line and generates 16x oversample ticks from the system clock. It runs the start/data/stop bit sequence, checks framing, and delivers each received byte through a valid/ready handshake, flagging framing errors and overruns. It sits between the pad-level `rxd` input and the byte consumer (FIFO or register interface).

## Interface
Parameters:
- `CLK_DIV`, 27: system clocks per oversample tick (50 MHz / 115200 / 16). Legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame. Legal range 5..8.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  receiver enable.
- `rxd`  in  1  raw serial line, asynchronous, idle high.
- `rx_data`  out  DATA_BITS  received byte, LSB = first data bit. Stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts when `rx_valid`&`rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: frame completed while previous byte unaccepted.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser to give `rxd_s`. All decisions use `rxd_s`.
- The tick divider counts 0..CLK_DIV-1. `os_tick` pulses when the count is CLK_DIV-1. The divider clears to 0 on IDLE→START and is held at 0 in IDLE.
- `os_cnt` (4 bit) counts ticks within the current bit. `bit_cnt` counts data bits.
- States:
  - IDLE: `rxd_s`=0 and `en`=1 → START, with `os_cnt`=0.
  - START: on the 8th tick (mid start bit), `rxd_s`=0 → DATA with `os_cnt`=0 and `bit_cnt`=0. `rxd_s`=1 → IDLE (glitch rejected, no flag).
  - DATA: on every 16th tick, shift `rxd_s` into the MSB of the shift register (right shift). After DATA_BITS samples → STOP.
  - STOP: on the 16th tick, `rxd_s`=1 → deliver and go to IDLE. `rxd_s`=0 → pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxd_s`=1, then → IDLE.
- Delivery happens in the cycle after the stop sample:
  - If `rx_valid`=0, or the old byte is accepted that same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise: pulse `overrun`, drop the new byte, keep the old byte and `rx_valid`.
- `en`=0 forces IDLE from any state. The in-flight frame is discarded with no flags. `rx_valid`/`rx_data` are unaffected.
- Reset values: state IDLE; all counters 0; synchroniser flops 1; `rx_data`=0; `rx_valid`, `frame_err`, `overrun`, `busy` = 0.

## Timing
- `rxd` falls at cycle 0: `rxd_s` low at cycle 2, START entered at cycle 3.
- Sample points: start bit at tick 8, data bit k at tick 8+16(k+1), stop at tick 8+16(DATA_BITS+1), counted from START entry. This is tick 152 for 8 data bits.
- `rx_valid` rises 1 cycle after the stop-sample tick. `frame_err` pulses in that same cycle.
- `rx_valid` falls the cycle after the handshake, unless a simultaneous delivery reloads it.
- `busy` is registered: it rises with START entry and falls with IDLE entry.

## Structure
- Package `uart_pkg` holds:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - `OVERSAMPLE`=16
  - `MID_SAMPLE`=8
- Sub-module `uart_baud_tick` (parameter CLK_DIV; ports `clk`, `reset`, `clr`, `tick`) is the divider. It is shareable with the transmitter.
- FSM, counters, shift register and handshake logic live in the top module.

## Test plan
- CLK_DIV=4, frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1), `rx_ready`=1 → `rx_valid` one cycle with `rx_data`=0xA5. No flags.
- 3-tick low glitch on idle line → START entered, then back to IDLE at tick 8. No `rx_valid`, no flags, `busy` drops.
- Frame 0x3C with stop bit 0, line held low for 2 more bit times → `frame_err` one pulse, no `rx_valid`. IDLE only after the line returns high. A following 0x55 frame is received correctly.
- `rx_ready`=0, frames 0x11 then 0x22 → `overrun` pulses at the second delivery and `rx_data` stays 0x11. After `rx_ready`, `rx_valid` drops.
- `rx_ready` asserted exactly in the delivery cycle of 0x22 while 0x11 is pending → 0x11 accepted, `rx_data`=0x22, `rx_valid` stays 1, no `overrun`.
- `en` dropped mid-DATA, or `reset` asserted mid-frame → IDLE next cycle (immediately on reset). Outputs at reset values; a clean 0xF0 frame afterwards is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: pulses tick once every CLK_DIV clocks, held at zero by clr.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rxd, samples mid-bit at 16x oversampling,
// checks framing and hands bytes to the consumer over a valid/ready handshake.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    rx_state_e state_q, state_d;
    logic                 rxd_meta_q, rxd_s_q;
    logic [3:0]           os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q;
    logic                 os_tick;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE),
        .tick  (os_tick)
    );

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && !rxd_s_q) begin
                    state_d  = START;
                    os_cnt_d = '0;
                end
            end
            START: begin
                if (os_tick) begin
                    if (os_cnt_q == 4'(MID_SAMPLE - 1)) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = rxd_s_q ? IDLE : DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (os_tick) begin
                    if (os_cnt_q == 4'(OVERSAMPLE - 1)) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shift_d   = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            state_d = STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (os_tick) begin
                    if (os_cnt_q == 4'(OVERSAMPLE - 1)) begin
                        os_cnt_d = '0;
                        if (rxd_s_q) begin
                            state_d = IDLE;
                            // A consumer accepting the old byte this cycle frees the slot.
                            if (!rx_valid_q || rx_ready) begin
                                rx_data_d  = shift_q;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d     = IDLE;
            rx_data_d   = rx_data_q;
            rx_valid_d  = rx_valid_q && !rx_ready;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= IDLE;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
